// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART control blocks (tx arbiter, future rx dispatch).
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int IDW         = $clog2(N_REQ_DEF);
  localparam int TIMEOUT_DEF = 8192;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping modulo N.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = IDW
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin : pick
    int j;
    j     = 0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!hit_o && req_i[j]) begin
        hit_o = 1'b1;
        idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers, with watchdog.
// Optional packet locking (hold the grant until a last_in byte completes): UART_TX_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  input  logic [N_REQ-1:0]          last_in,
  output logic [N_REQ-1:0]          ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      timeout_err
);

  localparam int GW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic [N_REQ-1:0]    req_eff;
  logic                pick_hit;
  logic [GW-1:0]       pick_idx;

  function automatic logic [WDW-1:0] sat_inc(input logic [WDW-1:0] v);
    if (&v) return v;
    return v + WDW'(1);
  endfunction

  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
    if (g == GW'(N_REQ - 1)) return '0;
    return g + GW'(1);
  endfunction

`ifdef UART_TX_ARB_PACKET_LOCK_EN
  logic lock_q, lock_d;
  logic lock_hold;

  // A locked grant only looks at its own requester; dropping that req in IDLE releases it.
  assign lock_hold = lock_q && req[grant_q];
  assign req_eff   = lock_hold ? (N_REQ'(1) << grant_q) : req;
`else
  logic unused_last;

  assign req_eff     = req;
  assign unused_last = ^last_in;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_pick (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    wd_d    = wd_q;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    lock_d  = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
        lock_d = lock_hold;
`endif
        if (pick_hit) begin
          // Registered outputs are loaded here so ack/tx_start appear with the START state.
          state_d         = START;
          grant_d         = pick_idx;
          data_d          = data_in[pick_idx*DATA_W +: DATA_W];
          ack_d[pick_idx] = 1'b1;
          start_d         = 1'b1;
          busy_d          = 1'b1;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
          lock_d          = !last_in[pick_idx];
`endif
        end
      end
      START: begin
        state_d = WAIT;
        busy_d  = 1'b1;
        wd_d    = '0;
      end
      WAIT: begin
        busy_d = 1'b1;
        wd_d   = sat_inc(wd_q);
        if (tx_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
          if (!lock_q) ptr_d = next_ptr(grant_q);
`else
          ptr_d   = next_ptr(grant_q);
`endif
        end else if (wd_d == WD_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          ptr_d   = next_ptr(grant_q);
`ifdef UART_TX_ARB_PACKET_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign ack         = ack_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected grants checked on every tx_start.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    last_in;
  logic [N-1:0]    ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic [15:0] sb[$];   // {requester id, byte}

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .last_in     (last_in),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    data_in[i*DW +: DW] = v;
  endtask

  task automatic push(input int id, input logic [7:0] v);
    sb.push_back({8'(id), v});
  endtask

  task automatic wait_start(output int id);
    logic seen;
    seen = 1'b0;
    id   = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        id   = int'(grant_id);
        break;
      end
    end
    chk("start_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Every start must match the head of the scoreboard; acks never appear outside a start.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", {31'b0, tx_start}, 32'd0);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          chk("sb_grant", 32'(grant_id), 32'(e[15:8]));
          chk("sb_ack", 32'(ack), 32'(4'b0001 << e[15:8]));
          chk("sb_data", 32'(tx_data), 32'(e[7:0]));
        end
      end else begin
        chk("ack_stray", 32'(ack), 32'd0);
      end
    end
  end

  initial begin
    int id;
    int s;
    int done_cyc;
    int cnt0;
    int cnt1;
    reset   = 1'b1;
    req     = '0;
    data_in = '0;
    last_in = '0;
    tx_done = 1'b0;
    done_cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // tx_done while idle is ignored
    reset = 1'b0;
    pulse_done();
    @(negedge clk);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start", 32'(tx_start), 32'd0);

    // Single requester: start one cycle after req is sampled, data held until tx_done
    req[1] = 1'b1;
    set_data(1, 8'hA5);
    push(1, 8'hA5);
    @(negedge clk);
    chk("s1_start", 32'(tx_start), 32'd1);
    chk("s1_ack", 32'(ack), 32'b0010);
    chk("s1_busy", 32'(busy), 32'd1);
    req[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("s1_hold", 32'(tx_data), 32'hA5);
      chk("s1_busy_wait", 32'(busy), 32'd1);
    end
    pulse_done();
    chk("s1_busy_after", 32'(busy), 32'd0);
    chk("s1_data_after", 32'(tx_data), 32'hA5);

    // All four requesting from pointer 0: 0,1,2,3,0; tx_done at d gives next start at d+2
    pulse_reset();
    req     = 4'hF;
    data_in = 32'h13121110;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    for (int f = 0; f < 5; f++) begin
      wait_start(id);
      if (f > 0) chk("rr_gap", 32'(cyc - done_cyc), 32'd2);
      if (f == 4) req = '0;
      repeat (20) @(negedge clk);
      done_cyc = cyc;
      pulse_done();
    end
    repeat (5) @(negedge clk);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Watchdog: no tx_done, abort pulse 64 cycles after the start cycle, then next requester
    pulse_reset();
    req = 4'b0001;
    set_data(0, 8'h77);
    push(0, 8'h77);
    wait_start(id);
    req = 4'b0010;
    set_data(1, 8'h88);
    push(1, 8'h88);
    repeat (63) @(negedge clk);
    chk("to_before", 32'(timeout_err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_next_start", 32'(tx_start), 32'd1);
    req = '0;
    // tx_done on the expiry cycle wins over the watchdog
    repeat (63) @(negedge clk);
    chk("co_before", 32'(timeout_err), 32'd0);
    pulse_done();
    chk("co_no_tmo", 32'(timeout_err), 32'd0);
    chk("co_busy", 32'(busy), 32'd0);

    // Reset in WAIT, then a stray tx_done
    pulse_reset();
    req = 4'b0100;
    set_data(2, 8'h3C);
    push(2, 8'h3C);
    wait_start(id);
    req = '0;
    repeat (3) @(negedge clk);
    pulse_reset();
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_start", 32'(tx_start), 32'd0);
    pulse_done();
    repeat (3) begin
      @(negedge clk);
      chk("rw_quiet_start", 32'(tx_start), 32'd0);
      chk("rw_quiet_busy", 32'(busy), 32'd0);
    end

    // req[2] withdrawn while busy; only requester 3 is served next
    req = 4'b0001;
    set_data(0, 8'h41);
    push(0, 8'h41);
    wait_start(id);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b1100;
    set_data(2, 8'h42);
    set_data(3, 8'h43);
    repeat (3) @(negedge clk);
    req[2] = 1'b0;
    push(3, 8'h43);
    repeat (3) @(negedge clk);
    pulse_done();
    wait_start(id);
    chk("drop_id", 32'(id), 32'd3);
    req = '0;
    repeat (3) @(negedge clk);
    pulse_done();
    repeat (3) @(negedge clk);
    chk("drop_idle", 32'(busy), 32'd0);

    // Packet of three bytes from requester 0 while requester 1 keeps requesting
    pulse_reset();
    cnt0 = 0;
    cnt1 = 0;
    set_data(0, 8'hB0);
    set_data(1, 8'hC0);
    last_in = 4'b0010;
    req     = 4'b0011;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
    push(0, 8'hB0); push(0, 8'hB1); push(0, 8'hB2); push(1, 8'hC0);
`else
    push(0, 8'hB0); push(1, 8'hC0); push(0, 8'hB1); push(1, 8'hC1);
`endif
    for (int f = 0; f < 4; f++) begin
      wait_start(id);
      if (ack[0]) begin
        cnt0++;
        set_data(0, 8'(8'hB0 + cnt0));
        last_in[0] = (cnt0 == 2);
        if (cnt0 == 3) req[0] = 1'b0;
      end else if (ack[1]) begin
        cnt1++;
        set_data(1, 8'(8'hC0 + cnt1));
      end
      if (f == 3) req = '0;
      repeat (3) @(negedge clk);
      pulse_done();
    end
    repeat (3) @(negedge clk);
    chk("pkt_idle", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
